fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the control inputs of the program-counter block and the instruction-memory request/response handshake. It arbitrates redirect sources (trap, jump, branch), keeps a single fetch outstanding, discards stale responses after a redirect, and presents fetched instructions to decode through a one-entry valid/ready output register. It sits between the PC register and the decode stage at the front of the core pipeline.

## Interface
- PC_WIDTH, 32, width of all addresses and of the PC
- INC_AMOUNT, 4, sequential PC step; must match the PC block's increment
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- pc_out  in  PC_WIDTH  current PC from the PC block
- pc_load / pc_inc / pc_stall  out  1 each  PC block control; at most one asserted per cycle
- pc_in  out  PC_WIDTH  redirect target to the PC block
- trap_valid, jmp_valid, br_valid  in  1 each  redirect requests
- trap_target, jmp_target, br_target  in  PC_WIDTH each  redirect targets
- imem_req  out  1  fetch request; imem_addr  out  PC_WIDTH
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  one-cycle response pulse; imem_rdata  in  32
- if_valid  out  1; if_pc  out  PC_WIDTH; if_instr  out  32  fetch output register
- if_ready  in  1  decode accepts the output register
- misalign_err  out  1; misalign_addr  out  PC_WIDTH  (see Configuration)

## Operation
- States: BOOT, REQ, WAIT, DROP, HALT. Reset to BOOT. Reset values: imem_req=0, pc_load=0, pc_inc=0, pc_stall=1, pc_in=0, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, misalign_addr=0.
- BOOT: one idle cycle, then REQ. The PC block loads reset_vector itself.
- REQ: imem_req = !if_valid || if_ready; imem_addr = pc_out. If imem_req && imem_gnt, go to WAIT.
- WAIT: on imem_rvalid, capture if_instr=imem_rdata, if_pc=pc_out, if_valid=1, pulse pc_inc, and go to REQ. The request gating guarantees the slot is free by then; rvalid is never dropped.
- DROP: a stale request is outstanding. On imem_rvalid, discard the data and go to REQ.
- Redirect: if any *_valid is asserted, priority is trap > jmp > br. pc_load=1 with pc_in set to the winning target. The same cycle clears if_valid next cycle. Next state:
  - WAIT without rvalid: DROP.
  - REQ with gnt: DROP.
  - WAIT with rvalid: REQ, response discarded with no pc_inc.
  - REQ without gnt: REQ. The imem may observe the address change before a grant.
  - DROP: stays in DROP; the new target is held in the PC.
  - HALT: only trap is honoured.
- pc_stall = !(pc_load || pc_inc).
- Output register: cleared by if_valid && if_ready unless refilled in the same cycle; held otherwise. A redirect overrides both.

## Timing
- Redirect in cycle N: pc_load in N, pc_out = target in N+1, imem_req with the target no earlier than N+1.
- Fetch latency: gnt in N, rvalid in M>N gives if_valid in M+1 and the incremented PC in M+1.
- Throughput: at most one instruction per 2 cycles (single outstanding request).
- Reset mid-operation: returns to BOOT next cycle; any later imem_rvalid from a pre-reset request is ignored by BOOT/REQ.
- pc_out wrap-around at 2^PC_WIDTH follows the PC block; fetch_ctrl treats it as ordinary.

## Configuration
- FETCH_CTRL_MISALIGN_EN defined: a jmp/br winner with target[1:0] != 0 is not loaded. Instead misalign_err pulses for 1 cycle, misalign_addr = target, the output register is cleared, an outstanding request is drained, and the FSM enters HALT. HALT leaves only on a trap redirect; trap targets are not checked.
- Undefined: misalign_err and misalign_addr are tied to 0 and all targets load unchecked.

## Test plan
- Reset with reset_vector=0x100, if_ready=1, imem gnt same cycle, rvalid next cycle -> if_pc 0x100, 0x104, 0x108 every 2 cycles; no pc_load.
- br_valid with br_target=0x200 while in WAIT, rvalid 2 cycles later with 0xDEAD -> 0xDEAD never appears on if_instr; next request addr 0x200; first if_pc=0x200.
- trap 0x80, jmp 0x300, br 0x400 in the same cycle -> pc_in=0x80; only pc_load asserted.
- if_ready=0 with if_valid=1 for 5 cycles -> imem_req=0 throughout; if_instr stable; fetch resumes the cycle if_ready rises.
- rvalid coincident with jmp to 0x40 -> response discarded, no pc_inc, next imem_addr=0x40.
- With FETCH_CTRL_MISALIGN_EN, br_target=0x202 -> misalign_err for 1 cycle, misalign_addr=0x202, no fetch until trap_valid with target 0x80, then fetch resumes at 0x80.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the PC block and decode.
//   Drives PC load/inc/stall, runs a single-outstanding imem req/gnt/rvalid
//   handshake, discards stale responses after a redirect, and holds fetched
//   instructions in a one-entry valid/ready output register.
//   Latency: gnt in N, rvalid in M>N -> if_valid in M+1. Redirect: pc_load in
//   the same cycle, new target requested from the next cycle.
//   Backpressure: no new request while the output register is full and decode
//   is not ready, so a response always finds a free slot.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pc_out / pc_load, pc_inc, pc_stall, pc_in   PC block interface
//   trap_*, jmp_*, br_*   redirect requests (priority trap > jmp > br)
//   imem_req/addr/gnt/rvalid/rdata              instruction memory handshake
//   if_valid/pc/instr, if_ready                 output register to decode
//   misalign_err/addr     misaligned jmp/br report
// Build option: define FETCH_CTRL_MISALIGN_EN to reject jmp/br targets with
//   target[1:0] != 0 (pulse misalign_err and halt until a trap). Without it
//   the misalign outputs are tied to zero and every target loads unchecked.

module fetch_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int INC_AMOUNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_load,
  output logic                pc_inc,
  output logic                pc_stall,
  output logic [PC_WIDTH-1:0] pc_in,
  input  logic                trap_valid,
  input  logic                jmp_valid,
  input  logic                br_valid,
  input  logic [PC_WIDTH-1:0] trap_target,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                if_valid,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [31:0]         if_instr,
  input  logic                if_ready,
  output logic                misalign_err,
  output logic [PC_WIDTH-1:0] misalign_addr
);

  // Sequential fetch addressing relies on whole 32-bit instruction steps.
  if ((INC_AMOUNT <= 0) || ((INC_AMOUNT % 4) != 0)) begin : g_inc_check
    $error("fetch_ctrl: INC_AMOUNT must be a positive multiple of 4");
  end

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_if_valid;
  logic [PC_WIDTH-1:0]   r_if_pc;
  logic [31:0]           r_if_instr;

  logic                  w_halted;
  logic                  w_halt_pend;
  logic                  w_redir;
  logic                  w_misalign;
  logic                  w_load;
  logic                  w_req;
  logic                  w_capture;
  logic [PC_WIDTH-1:0]   w_target;

  // Redirect arbitration: later assignments win, giving trap > jmp > br.
  always_comb begin
    w_target = br_target;
    if (jmp_valid)  w_target = jmp_target;
    if (trap_valid) w_target = trap_target;
  end

  // While halted (or draining towards HALT) only a trap may redirect.
  assign w_halted = (r_state == S_HALT) || w_halt_pend;
  assign w_redir  = trap_valid || (!w_halted && (jmp_valid || br_valid));

`ifdef FETCH_CTRL_MISALIGN_EN
  logic                r_mis_err;
  logic [PC_WIDTH-1:0] r_mis_addr;
  logic                r_halt_pend;

  // Trap targets are trusted; only a jmp/br winner is checked.
  assign w_misalign  = w_redir && !trap_valid && (w_target[1:0] != 2'b00);
  assign w_halt_pend = r_halt_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mis_err   <= 1'b0;
      r_mis_addr  <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_mis_err <= w_misalign;
      if (w_misalign) r_mis_addr <= w_target;
      // Remembers that the DROP in progress must end in HALT, not REQ.
      r_halt_pend <= (w_next == S_DROP) &&
                     (w_misalign || (r_halt_pend && !w_load));
    end
  end

  assign misalign_err  = r_mis_err;
  assign misalign_addr = r_mis_addr;
`else
  assign w_misalign    = 1'b0;
  assign w_halt_pend   = 1'b0;
  assign misalign_err  = 1'b0;
  assign misalign_addr = '0;
`endif

  assign w_load = w_redir && !w_misalign;

  // Next state and request/capture decisions.
  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_BOOT: w_next = w_misalign ? S_HALT : S_REQ;
      S_REQ: begin
        // Only request when the output slot will be free for the response.
        w_req = !r_if_valid || if_ready;
        if (w_req && imem_gnt) begin
          // A redirect in the grant cycle makes the accepted fetch stale.
          w_next = w_redir ? S_DROP : S_WAIT;
        end else if (w_misalign) begin
          w_next = S_HALT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (w_misalign) begin
            w_next = S_HALT;
          end else begin
            w_next    = S_REQ;
            w_capture = !w_load;
          end
        end else if (w_redir) begin
          w_next = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_next = (w_misalign || (w_halt_pend && !w_load)) ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (w_load) w_next = S_REQ;
      end
      default: w_next = S_BOOT;
    endcase
  end

  // Combinational outputs are forced idle while reset is asserted.
  assign imem_req  = rst_n && w_req;
  assign imem_addr = pc_out;
  assign pc_load   = rst_n && w_load;
  assign pc_inc    = rst_n && w_capture;
  assign pc_in     = pc_load ? w_target : '0;
  assign pc_stall  = !(pc_load || pc_inc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_state <= w_next;
      // Any redirect or misalign flushes the slot; data fields are kept.
      if (w_redir) begin
        r_if_valid <= 1'b0;
      end else if (w_capture) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= pc_out;
        r_if_instr <= imem_rdata;
      end else if (r_if_valid && if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl.
//   Each vector holds one cycle of inputs and the outputs expected in that
//   cycle; the PC block is modelled here (reset vector 0x100, step 4).
//   Misalign vectors are selected by FETCH_CTRL_MISALIGN_EN like the DUT.

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out;
  logic        pc_load, pc_inc, pc_stall;
  logic [31:0] pc_in;
  logic        trap_valid, jmp_valid, br_valid;
  logic [31:0] trap_target, jmp_target, br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        if_ready;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.PC_WIDTH(32), .INC_AMOUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_stall(pc_stall), .pc_in(pc_in),
    .trap_valid(trap_valid), .jmp_valid(jmp_valid), .br_valid(br_valid),
    .trap_target(trap_target), .jmp_target(jmp_target), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  // PC block model.
  always @(posedge clk) begin
    if (!rst_n)       pc_out <= 32'h100;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc)  pc_out <= pc_out + 32'd4;
  end

  typedef struct {
    logic        rst_n, rdy, gnt, rv;
    logic [31:0] rdata;
    logic        tv;  logic [31:0] tt;
    logic        jv;  logic [31:0] jt;
    logic        bv;  logic [31:0] bt;
    logic [4:0]  e_ctl;   // {imem_req, pc_load, pc_inc, pc_stall, if_valid}
    logic [31:0] e_addr, e_pcin, e_ipc, e_instr;
    logic        e_merr;
    logic [31:0] e_maddr;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic rdy, input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic tv, input logic [31:0] tt, input logic jv, input logic [31:0] jt,
    input logic bv, input logic [31:0] bt,
    input logic [4:0] ctl, input logic [31:0] addr, input logic [31:0] pcin,
    input logic [31:0] ipc, input logic [31:0] instr);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.tv = tv; v.tt = tt; v.jv = jv; v.jt = jt; v.bv = bv; v.bt = bt;
    v.e_ctl = ctl; v.e_addr = addr; v.e_pcin = pcin; v.e_ipc = ipc; v.e_instr = instr;
    v.e_merr = 1'b0; v.e_maddr = 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector shortly after the edge, check before the next edge.
  task automatic run_vec(input vec_t v, input string tag);
    rst_n       = v.rst_n;
    if_ready    = v.rdy;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    trap_valid  = v.tv; trap_target = v.tt;
    jmp_valid   = v.jv; jmp_target  = v.jt;
    br_valid    = v.bv; br_target   = v.bt;
    #3;
    chk({tag, " ctl"},   {27'd0, imem_req, pc_load, pc_inc, pc_stall, if_valid}, {27'd0, v.e_ctl});
    chk({tag, " addr"},  imem_addr, v.e_addr);
    chk({tag, " pc_in"}, pc_in,     v.e_pcin);
    chk({tag, " if_pc"}, if_pc,     v.e_ipc);
    chk({tag, " instr"}, if_instr,  v.e_instr);
    chk({tag, " merr"},  {31'd0, misalign_err}, {31'd0, v.e_merr});
    chk({tag, " maddr"}, misalign_addr, v.e_maddr);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t hs[$];
  vec_t tmp;

  initial begin
    // Main sequence. Columns: rst rdy gnt rv rdata | tv tt jv jt bv bt | ctl addr pc_in if_pc instr
    tbl.push_back(mk(0,1,1,0,32'h0,        0,0,0,0,0,0, 5'b00010, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b00010, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1,1,1,1,32'h11111111, 0,0,0,0,0,0, 5'b00100, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10011, 32'h104, 0, 32'h100, 32'h11111111));
    tbl.push_back(mk(1,1,1,1,32'h22222222, 0,0,0,0,0,0, 5'b00100, 32'h104, 0, 32'h100, 32'h11111111));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10011, 32'h108, 0, 32'h104, 32'h22222222));
    tbl.push_back(mk(1,1,1,1,32'h33333333, 0,0,0,0,0,0, 5'b00100, 32'h108, 0, 32'h104, 32'h22222222));
    // Decode stalls for 5 cycles: no request, output held.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,1,0,32'h0,      0,0,0,0,0,0, 5'b00011, 32'h10C, 0, 32'h108, 32'h33333333));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10011, 32'h10C, 0, 32'h108, 32'h33333333));
    // Branch while waiting; stale 0xDEAD must be dropped.
    tbl.push_back(mk(1,1,0,0,32'h0,        0,0,0,0,1,32'h200, 5'b01000, 32'h10C, 32'h200, 32'h108, 32'h33333333));
    tbl.push_back(mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b00010, 32'h200, 0, 32'h108, 32'h33333333));
    tbl.push_back(mk(1,1,0,1,32'hDEAD,     0,0,0,0,0,0, 5'b00010, 32'h200, 0, 32'h108, 32'h33333333));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h200, 0, 32'h108, 32'h33333333));
    tbl.push_back(mk(1,1,1,1,32'h44444444, 0,0,0,0,0,0, 5'b00100, 32'h200, 0, 32'h108, 32'h33333333));
    // All three redirects at once in REQ without grant: trap wins.
    tbl.push_back(mk(1,1,0,0,32'h0,        1,32'h80,1,32'h300,1,32'h400, 5'b11001, 32'h204, 32'h80, 32'h200, 32'h44444444));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h80, 0, 32'h200, 32'h44444444));
    // Response coincident with a jump: discarded, no pc_inc.
    tbl.push_back(mk(1,1,1,1,32'h55555555, 0,0,1,32'h40,0,0, 5'b01000, 32'h80, 32'h40, 32'h200, 32'h44444444));
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h40, 0, 32'h200, 32'h44444444));
    tbl.push_back(mk(1,1,1,1,32'h66666666, 0,0,0,0,0,0, 5'b00100, 32'h40, 0, 32'h200, 32'h44444444));
    tbl.push_back(mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b10011, 32'h44, 0, 32'h40, 32'h66666666));
    // Redirect in the grant cycle: fetch becomes stale, go through DROP.
    tbl.push_back(mk(1,1,1,0,32'h0,        0,0,1,32'h500,0,0, 5'b11000, 32'h44, 32'h500, 32'h40, 32'h66666666));
    tbl.push_back(mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b00010, 32'h500, 0, 32'h40, 32'h66666666));
    tbl.push_back(mk(1,1,0,1,32'h77777777, 0,0,0,0,0,0, 5'b00010, 32'h500, 0, 32'h40, 32'h66666666));
    tbl.push_back(mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h500, 0, 32'h40, 32'h66666666));
    // Reset mid-operation; stale rvalids afterwards are ignored.
    tbl.push_back(mk(0,1,0,0,32'h0,        0,0,1,32'h600,0,0, 5'b00010, 32'h500, 0, 32'h40, 32'h66666666));
    tbl.push_back(mk(1,1,0,1,32'h88888888, 0,0,0,0,0,0, 5'b00010, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1,1,0,1,32'h88888888, 0,0,0,0,0,0, 5'b10010, 32'h100, 0, 0, 0));

`ifdef FETCH_CTRL_MISALIGN_EN
    // Misaligned branch: not loaded, error pulse, halt until a trap.
    hs.push_back(mk(1,1,0,0,32'h0, 0,0,0,0,1,32'h202, 5'b10010, 32'h100, 0, 0, 0));
    tmp = mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b00010, 32'h100, 0, 0, 0);
    tmp.e_merr = 1'b1; tmp.e_maddr = 32'h202; hs.push_back(tmp);
    tmp = mk(1,1,1,0,32'h0,        0,0,1,32'h300,0,0, 5'b00010, 32'h100, 0, 0, 0);
    tmp.e_maddr = 32'h202; hs.push_back(tmp);
    tmp = mk(1,1,0,0,32'h0,        1,32'h80,0,0,0,0, 5'b01000, 32'h100, 32'h80, 0, 0);
    tmp.e_maddr = 32'h202; hs.push_back(tmp);
    tmp = mk(1,1,1,0,32'h0,        0,0,0,0,0,0, 5'b10010, 32'h80, 0, 0, 0);
    tmp.e_maddr = 32'h202; hs.push_back(tmp);
    tmp = mk(1,1,1,1,32'h99999999, 0,0,0,0,0,0, 5'b00100, 32'h80, 0, 0, 0);
    tmp.e_maddr = 32'h202; hs.push_back(tmp);
    tmp = mk(1,1,0,0,32'h0,        0,0,0,0,0,0, 5'b10011, 32'h84, 0, 32'h80, 32'h99999999);
    tmp.e_maddr = 32'h202; hs.push_back(tmp);
`else
    // Without the check, a misaligned branch target loads like any other.
    hs.push_back(mk(1,1,0,0,32'h0, 0,0,0,0,1,32'h202, 5'b11000, 32'h100, 32'h202, 0, 0));
    hs.push_back(mk(1,1,0,0,32'h0, 0,0,0,0,0,0,       5'b10010, 32'h202, 0, 0, 0));
`endif

    // Initial reset edge.
    rst_n = 1'b0; if_ready = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    trap_valid = 1'b0; jmp_valid = 1'b0; br_valid = 1'b0;
    trap_target = '0; jmp_target = '0; br_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < hs.size(); i++)  run_vec(hs[i],  $sformatf("seq%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
